inst_loader: RTL

- UART-side writer that fills the instruction memory the pipelined MIPS datapath fetches from, then gates CPU execution (run / single-step / halt).
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words and issues word writes to the instruction memory write port.
- Drives the CPU enable that qualifies PC and pipeline-register updates.
- Sits between the UART RX and the datapath top level.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/inst_loader_if.sv | 31 +++
 rtl/word_assembler.sv | 37 +++
 rtl/inst_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and command bytes for inst_loader. Rev 1.0
// LOADER_CHECKSUM_EN adds the CSUM state.
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_RUN    = 3'd4,
    ST_STEP   = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , ST_CSUM = 3'd6
`endif
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;

endpackage

`default_nettype wire

// File: rtl/inst_loader_if.sv
// inst_loader_if: UART-side / datapath-side signal bundle for inst_loader. Rev 1.0
`default_nettype none

interface inst_loader_if #(
  parameter int NBITS = 32
);

  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             i_halt;
  logic             o_im_we;
  logic [NBITS-1:0] o_im_addr;
  logic [NBITS-1:0] o_im_data;
  logic             o_cpu_en;
  logic             o_busy;
  logic             o_err;

  // Driving side: UART receiver and datapath feeding the loader.
  modport master (
    output i_rx_data, i_rx_valid, i_halt,
    input  o_im_we, o_im_addr, o_im_data, o_cpu_en, o_busy, o_err
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_halt,
    output o_im_we, o_im_addr, o_im_data, o_cpu_en, o_busy, o_err
  );

endinterface

`default_nettype wire

// File: rtl/word_assembler.sv
// word_assembler: collects four bytes little-endian, flags the 4th byte combinationally. Rev 1.0
`default_nettype none

module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (en && valid) begin
      shift_q <= {byte_in, shift_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The completing byte is merged on the fly so the write can issue on the next edge.
  assign word      = {byte_in, shift_q};
  assign word_done = en && valid && (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// inst_loader: UART byte-stream loader for instruction memory plus CPU run/step gating. Rev 1.0
// Optional: LOADER_CHECKSUM_EN appends an XOR checksum byte after the payload.
`default_nettype none

module inst_loader
  import loader_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int MEM_SIZE = 1024,
  parameter int CNTBITS  = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  inst_loader_if.slave bus
);

  localparam logic [CNTBITS:0] MAX_WORDS = (CNTBITS+1)'(MEM_SIZE / 4);

  state_t             state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [CNTBITS-1:0] count_q, count_d;
  logic [CNTBITS-1:0] index_q, index_d;
  logic [CNTBITS-1:0] index_inc;
  logic [CNTBITS-1:0] len_full;
  logic               im_we_q, im_we_d;
  logic [NBITS-1:0]   im_addr_q, im_addr_d;
  logic [NBITS-1:0]   im_data_q, im_data_d;
  logic               cpu_en_q, cpu_en_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               asm_en, asm_clr;
  logic               word_done;
  logic [31:0]        word;
  logic               halt_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  word_assembler u_asm (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .clr       (asm_clr),
    .en        (asm_en),
    .valid     (bus.i_rx_valid),
    .byte_in   (bus.i_rx_data),
    .word      (word),
    .word_done (word_done)
  );

  assign len_full  = CNTBITS'({bus.i_rx_data, len_lo_q});
  assign index_inc = index_q + CNTBITS'(1);
  assign halt_byte = bus.i_rx_valid && (bus.i_rx_data == CMD_HALT);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      len_lo_q  <= '0;
      count_q   <= '0;
      index_q   <= '0;
      im_we_q   <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      count_q   <= count_d;
      index_q   <= index_d;
      im_we_q   <= im_we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      cpu_en_q  <= cpu_en_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    count_d   = count_q;
    index_d   = index_q;
    im_we_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    err_d     = err_q;
    asm_en    = 1'b0;
    asm_clr   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_LOAD: begin
              state_d = ST_LEN_LO;
              err_d   = 1'b0;
            end
            CMD_RUN: begin
              state_d = ST_RUN;
              err_d   = 1'b0;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
              err_d   = 1'b0;
            end
            CMD_HALT: err_d = 1'b0;
            default:  err_d = 1'b1;
          endcase
        end
      end

      ST_LEN_LO: begin
        if (bus.i_rx_valid) begin
          len_lo_d = bus.i_rx_data;
          state_d  = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (bus.i_rx_valid) begin
          if (len_full == '0) begin
            state_d = ST_IDLE;
          end else if ({1'b0, len_full} > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            count_d = len_full;
            index_d = '0;
            asm_clr = 1'b1;
            state_d = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
      end

      ST_DATA: begin
        asm_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (bus.i_rx_valid) csum_d = csum_q ^ bus.i_rx_data;
`endif
        if (word_done) begin
          im_we_d   = 1'b1;
          im_addr_d = NBITS'({index_q, 2'b00});
          im_data_d = NBITS'(word);
          index_d   = index_inc;
          // Leave on the edge that raises the final write strobe.
          if (index_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end

      ST_RUN: begin
        if (bus.i_halt || halt_byte) state_d = ST_IDLE;
      end

      ST_STEP: state_d = ST_IDLE;

`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data != csum_q) err_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Registering from the next state keeps these outputs aligned with state_q.
    cpu_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    busy_d   = (state_d != ST_IDLE);
  end

  assign bus.o_im_we   = im_we_q;
  assign bus.o_im_addr = im_addr_q;
  assign bus.o_im_data = im_data_q;
  assign bus.o_cpu_en  = cpu_en_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_err     = err_q;

endmodule

`default_nettype wire
